// File: rtl/alu_bist.sv
`default_nettype none
// ============================================================================
// Module   : alu_bist
// Purpose  : Self-test initiator for the RV32 ALU. Drives 8 directed vectors
//            and NUM_VECTORS LFSR vectors, checks result/flags against an
//            internal golden model and counts failing vectors.
//            Optional first-fail capture: define ALU_BIST_FIRST_FAIL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_bist #(
    parameter int          NUM_VECTORS = 100,
    parameter logic [31:0] SEED_A      = 32'h0000_0001,
    parameter logic [31:0] SEED_B      = 32'h0000_ACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] error_count,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_sign,
    output logic [31:0] fail_a,
    output logic [31:0] fail_b,
    output logic [2:0]  fail_ctrl,
    output logic [31:0] fail_result
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_DRIVE = 2'd1;
    localparam logic [1:0]  c_ST_CHECK = 2'd2;
    localparam logic [1:0]  c_ST_DONE  = 2'd3;
    localparam logic [31:0] c_TAPS     = 32'h8020_0003;
    localparam logic [16:0] c_LAST_IDX = 17'(8 + NUM_VECTORS - 1);

    logic [1:0]  r_state;
    logic [16:0] r_idx;
    logic [31:0] r_lfsr_a;
    logic [31:0] r_lfsr_b;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [15:0] r_err;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_ctrl;

    logic [31:0] w_exp;
    logic        w_flag_chk;
    logic        w_res_bad;
    logic        w_zero_bad;
    logic        w_sign_bad;
    logic        w_bad;
    logic [15:0] w_err_next;
    logic [16:0] w_idx_nxt;
    logic        w_last;
    logic        w_rand;
    logic [31:0] w_lfsr_a_nxt;
    logic [31:0] w_lfsr_b_nxt;
    logic        w_start_run;

    always_comb begin
        w_exp = 32'd0;
        case (r_ctrl)
            3'b000:  w_exp = r_a + r_b;
            3'b001:  w_exp = r_a << r_b[4:0];
            3'b010:  w_exp = r_a - r_b;
            3'b011:  w_exp = 32'd0;
            3'b100:  w_exp = r_a ^ r_b;
            3'b101:  w_exp = r_a >> r_b[4:0];
            3'b110:  w_exp = r_a | r_b;
            3'b111:  w_exp = r_a & r_b;
            default: w_exp = 32'd0;
        endcase
    end

    // Case-inequality so that X/Z from the ALU is treated as a failure.
    assign w_flag_chk = (r_ctrl == 3'b000) || (r_ctrl == 3'b010);
    assign w_res_bad  = (alu_result !== w_exp);
    assign w_zero_bad = (alu_zero !== (w_exp == 32'd0));
    assign w_sign_bad = (alu_sign !== w_exp[31]);
    assign w_bad      = w_res_bad || (w_flag_chk && (w_zero_bad || w_sign_bad));
    assign w_err_next = (w_bad && (r_err != 16'hFFFF)) ? r_err + 16'd1 : r_err;

    assign w_idx_nxt   = r_idx + 17'd1;
    assign w_last      = (r_idx == c_LAST_IDX);
    assign w_rand      = (w_idx_nxt > 17'd7);
    assign w_start_run = ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE)) && start;

    assign w_lfsr_a_nxt = (r_lfsr_a >> 1) ^ (r_lfsr_a[0] ? c_TAPS : 32'd0);
    assign w_lfsr_b_nxt = (r_lfsr_b >> 1) ^ (r_lfsr_b[0] ? c_TAPS : 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_idx    <= 17'd0;
            r_lfsr_a <= SEED_A;
            r_lfsr_b <= SEED_B;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= 16'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_ctrl   <= 3'd0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_state  <= c_ST_DRIVE;
                        r_idx    <= 17'd0;
                        r_lfsr_a <= SEED_A;
                        r_lfsr_b <= SEED_B;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                        r_err    <= 16'd0;
                        r_a      <= 32'd1;
                        r_b      <= 32'd2;
                        r_ctrl   <= 3'd0;
                    end
                end
                c_ST_DRIVE: r_state <= c_ST_CHECK;
                c_ST_CHECK: begin
                    r_err <= w_err_next;
                    if (w_last) begin
                        r_state <= c_ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 16'd0);
                    end else begin
                        r_state <= c_ST_DRIVE;
                        r_idx   <= w_idx_nxt;
                        if (w_rand) begin
                            r_a      <= r_lfsr_a;
                            r_b      <= r_lfsr_b;
                            r_ctrl   <= r_lfsr_a[31:29];
                            r_lfsr_a <= w_lfsr_a_nxt;
                            r_lfsr_b <= w_lfsr_b_nxt;
                        end else begin
                            r_a    <= 32'd1;
                            r_b    <= 32'd2;
                            r_ctrl <= w_idx_nxt[2:0];
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign error_count = r_err;
    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_ctrl    = r_ctrl;

`ifdef ALU_BIST_FIRST_FAIL_EN
    logic        r_fail_seen;
    logic [31:0] r_fail_a;
    logic [31:0] r_fail_b;
    logic [2:0]  r_fail_ctrl;
    logic [31:0] r_fail_result;

    always_ff @(posedge clk) begin
        if (reset || w_start_run) begin
            r_fail_seen   <= 1'b0;
            r_fail_a      <= 32'd0;
            r_fail_b      <= 32'd0;
            r_fail_ctrl   <= 3'd0;
            r_fail_result <= 32'd0;
        end else if ((r_state == c_ST_CHECK) && w_bad && !r_fail_seen) begin
            r_fail_seen   <= 1'b1;
            r_fail_a      <= r_a;
            r_fail_b      <= r_b;
            r_fail_ctrl   <= r_ctrl;
            r_fail_result <= alu_result;
        end
    end

    assign fail_a      = r_fail_a;
    assign fail_b      = r_fail_b;
    assign fail_ctrl   = r_fail_ctrl;
    assign fail_result = r_fail_result;
`else
    logic w_unused_start_run;
    assign w_unused_start_run = w_start_run;
    assign fail_a      = 32'd0;
    assign fail_b      = 32'd0;
    assign fail_ctrl   = 3'd0;
    assign fail_result = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_bist.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_bist
// Purpose  : Scoreboard bench for alu_bist with a mode-switchable ALU model
//            (correct / A+B stub / Zero stuck at 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_bist;

    localparam int c_NV = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] error_count;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_sign;
    logic [31:0] fail_a;
    logic [31:0] fail_b;
    logic [2:0]  fail_ctrl;
    logic [31:0] fail_result;
    logic [1:0]  alu_mode;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [15:0] err;
        logic        pass;
        logic [31:0] fa;
        logic [31:0] fb;
        logic [2:0]  fc;
        logic [31:0] fr;
    } done_t;

    vec_t  vq[$];
    done_t dq[$];

    alu_bist #(.NUM_VECTORS(c_NV)) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .fail_a(fail_a), .fail_b(fail_b), .fail_ctrl(fail_ctrl), .fail_result(fail_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU under test: mode 0 correct, 1 returns A+B for all ops, 2 Zero stuck high
    always_comb begin
        alu_result = 32'd0;
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a << alu_b[4:0];
            3'b010:  alu_result = alu_a - alu_b;
            3'b011:  alu_result = 32'd0;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = alu_a >> alu_b[4:0];
            3'b110:  alu_result = alu_a | alu_b;
            default: alu_result = alu_a & alu_b;
        endcase
        if (alu_mode == 2'd1) alu_result = alu_a + alu_b;
        alu_zero = (alu_result == 32'd0);
        alu_sign = alu_result[31];
        if (alu_mode == 2'd2) alu_zero = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_err"}, 32'(error_count), 32'd0);
        check({tag, "_alu_a"}, alu_a, 32'd0);
        check({tag, "_alu_b"}, alu_b, 32'd0);
        check({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
        check({tag, "_fail_a"}, fail_a, 32'd0);
        check({tag, "_fail_result"}, fail_result, 32'd0);
    endtask

    // Hand-computed run vectors: 8 directed, then seeds, then one LFSR step of each
    task automatic push_vectors();
        vec_t v;
        for (int k = 0; k < 8; k++) begin
            v.a = 32'd1; v.b = 32'd2; v.ctrl = 3'(k);
            vq.push_back(v);
        end
        v.a = 32'h0000_0001; v.b = 32'h0000_ACE1; v.ctrl = 3'b000;
        vq.push_back(v);
        v.a = 32'h8020_0003; v.b = 32'h8020_5673; v.ctrl = 3'b100;
        vq.push_back(v);
    endtask

    task automatic push_done(input int c, input logic [15:0] err, input logic p,
                             input logic [31:0] fa, input logic [31:0] fb,
                             input logic [2:0] fc, input logic [31:0] fr);
        done_t d;
        d.cyc = c; d.err = err; d.pass = p;
`ifdef ALU_BIST_FIRST_FAIL_EN
        d.fa = fa; d.fb = fb; d.fc = fc; d.fr = fr;
`else
        d.fa = 32'd0; d.fb = 32'd0; d.fc = 3'd0; d.fr = 32'd0;
        if (fa == fb && fc == 3'd7 && fr == 32'd0) d.fr = 32'd0;
`endif
        dq.push_back(d);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((dq.size() > 0 || vq.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dq.size() > 0 || vq.size() > 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d done and %0d vectors still pending after %0d cycles",
                     dq.size(), vq.size(), budget);
            dq.delete();
            vq.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_pulse(input logic [1:0] mode, input logic [15:0] err, input logic p,
                             input logic [31:0] fa, input logic [31:0] fb,
                             input logic [2:0] fc, input logic [31:0] fr);
        alu_mode = mode;
        push_vectors();
        push_done(cyc + 21, err, p, fa, fb, fc, fr);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain(100);
    endtask

    // Monitor: vectors checked on the first cycle each is presented, results on done rise
    initial begin : monitor
        logic  busy_q;
        logic  done_q;
        int    phase;
        vec_t  v;
        done_t d;
        busy_q = 1'b0;
        done_q = 1'b0;
        phase  = 0;
        forever begin
            @(negedge clk);
            if (busy && !busy_q) phase = 0;
            if (busy) begin
                if (phase == 0 && vq.size() > 0) begin
                    v = vq.pop_front();
                    check("vec_a", alu_a, v.a);
                    check("vec_b", alu_b, v.b);
                    check("vec_ctrl", 32'(alu_ctrl), 32'(v.ctrl));
                end
                phase ^= 1;
            end
            if (done && !done_q) begin
                if (dq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: done rose at cycle %0d with no run expected", cyc);
                end else begin
                    d = dq.pop_front();
                    check("done_cycle", 32'(cyc), 32'(d.cyc));
                    check("done_err", 32'(error_count), 32'(d.err));
                    check("done_pass", 32'(pass), 32'(d.pass));
                    check("done_busy", 32'(busy), 32'd0);
                    check("fail_a", fail_a, d.fa);
                    check("fail_b", fail_b, d.fb);
                    check("fail_ctrl", 32'(fail_ctrl), 32'(d.fc));
                    check("fail_result", fail_result, d.fr);
                end
            end
            busy_q = busy;
            done_q = done;
        end
    end

    initial begin : stimulus
        int c;
        reset    = 1'b1;
        start    = 1'b0;
        alu_mode = 2'd0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Correct ALU: clean run
        run_pulse(2'd0, 16'd0, 1'b1, 32'd0, 32'd0, 3'd0, 32'd0);

        // A+B stub with start held high: second run begins on the edge after done
        alu_mode = 2'd1;
        push_vectors();
        push_vectors();
        c = cyc;
        push_done(c + 21, 16'd6, 1'b0, 32'd1, 32'd2, 3'b001, 32'd3);
        push_done(c + 42, 16'd6, 1'b0, 32'd1, 32'd2, 3'b001, 32'd3);
        start = 1'b1;
        repeat (22) @(negedge clk);
        check("restart_err_clear", 32'(error_count), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        start = 1'b0;
        wait_drain(100);

        // Zero stuck high: ADD x2 and SUB vectors fail
        run_pulse(2'd2, 16'd3, 1'b0, 32'd1, 32'd2, 3'b000, 32'd3);

        // Reset in the middle of a failing run
        alu_mode = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("midrun_err", 32'(error_count), 32'd2);
        check("midrun_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midreset");
        reset = 1'b0;
        @(negedge clk);

        // Fresh run after reset reproduces the clean result
        run_pulse(2'd0, 16'd0, 1'b1, 32'd0, 32'd0, 3'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
